// File: rtl/rom_sync_arb_if.sv
// Request/response bus for rom_sync_arb: CH independent read channels packed side by side.
// A transfer on either channel direction happens in a cycle where valid and ready are both 1.
// A producer holds valid and its payload stable until that cycle, and never waits for ready before raising valid.
interface rom_sync_arb_if #(
    parameter int CH    = 2,
    parameter int ADDRW = 8,
    parameter int WIDTH = 8
);
    logic [CH-1:0]       req_valid;
    logic [CH-1:0]       req_ready;
    logic [CH*ADDRW-1:0] req_addr;
    logic [CH-1:0]       resp_valid;
    logic [CH-1:0]       resp_ready;
    logic [CH*WIDTH-1:0] resp_data;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/rom_sync_arb.sv
// Synchronous ROM shared by CH read channels through a round-robin arbiter.
// One read is issued per cycle. Each channel owns a RESP register that absorbs consumer backpressure.
module rom_sync_arb #(
    parameter int    WIDTH   = 8,
    parameter int    DEPTH   = 256,
    parameter string INIT_F  = "",
    parameter int    CH      = 2,
    parameter int    LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    rom_sync_arb_if.slave     bus,
    output logic [2*CH-1:0]   dbg_state
);
    localparam int ADDRW = $clog2(DEPTH);
    localparam int CHW   = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ISSUED = 2'd2,
        ST_RESP   = 2'd3
    } ch_state_t;

    ch_state_t        state_q [CH];
    ch_state_t        state_d [CH];
    logic [ADDRW-1:0] addr_q  [CH];
    logic [WIDTH-1:0] data_q  [CH];
    logic [CHW-1:0]   ptr_q;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             grant_vld;
    logic [CHW-1:0]   grant_id;
    logic [ADDRW-1:0] rd_addr;
    logic [WIDTH-1:0] mem_rd;
    logic             tail_valid;
    logic [CHW-1:0]   tail_id;
    logic [WIDTH-1:0] tail_data;

    // Round-robin search starts one past the last granted channel; only WAIT channels compete.
    always_comb begin
        int             idx;
        logic [CHW-1:0] idx_b;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        idx_b     = '0;
        for (int i = 0; i < CH; i++) begin
            idx = int'(ptr_q) + 1 + i;
            if (idx >= CH) idx = idx - CH;
            idx_b = CHW'(idx);
            if (!grant_vld && state_q[idx_b] == ST_WAIT) begin
                grant_vld = 1'b1;
                grant_id  = idx_b;
            end
        end
    end

    // Addresses beyond DEPTH read as zero rather than aliasing into the table.
    always_comb begin
        rd_addr = addr_q[grant_id];
        mem_rd  = '0;
        if (int'(rd_addr) < DEPTH) mem_rd = mem[rd_addr];
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            always_comb begin
                tail_valid = grant_vld;
                tail_id    = grant_id;
                tail_data  = mem_rd;
            end
        end else begin : g_lat2
            logic             p1_valid;
            logic [CHW-1:0]   p1_id;
            logic [WIDTH-1:0] p1_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p1_valid <= 1'b0;
                    p1_id    <= '0;
                    p1_data  <= '0;
                end else begin
                    p1_valid <= grant_vld;
                    p1_id    <= grant_id;
                    p1_data  <= mem_rd;
                end
            end

            always_comb begin
                tail_valid = p1_valid;
                tail_id    = p1_id;
                tail_data  = p1_data;
            end
        end
    endgenerate

    // Channel FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) state_q[c] <= ST_IDLE;
        end else begin
            for (int c = 0; c < CH; c++) state_q[c] <= state_d[c];
        end
    end

    // Channel FSM: next state. With LATENCY=1 read data lands in the grant edge, so WAIT can skip ISSUED.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            state_d[c] = state_q[c];
            case (state_q[c])
                ST_IDLE:   if (bus.req_valid[c]) state_d[c] = ST_WAIT;
                ST_WAIT: begin
                    if (tail_valid && tail_id == CHW'(c))       state_d[c] = ST_RESP;
                    else if (grant_vld && grant_id == CHW'(c))  state_d[c] = ST_ISSUED;
                end
                ST_ISSUED: if (tail_valid && tail_id == CHW'(c)) state_d[c] = ST_RESP;
                ST_RESP:   if (bus.resp_ready[c]) state_d[c] = ST_IDLE;
                default:   state_d[c] = ST_IDLE;
            endcase
        end
    end

    // Channel FSM: outputs. req_ready is gated by rst_n so nothing is accepted during reset.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            bus.req_ready[c]                 = rst_n && (state_q[c] == ST_IDLE);
            bus.resp_valid[c]                = (state_q[c] == ST_RESP);
            bus.resp_data[c*WIDTH +: WIDTH]  = data_q[c];
            dbg_state[2*c +: 2]              = state_q[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= CHW'(CH - 1);
            for (int c = 0; c < CH; c++) begin
                addr_q[c] <= '0;
                data_q[c] <= '0;
            end
        end else begin
            if (grant_vld) ptr_q <= grant_id;
            for (int c = 0; c < CH; c++) begin
                if (state_q[c] == ST_IDLE && bus.req_valid[c])
                    addr_q[c] <= bus.req_addr[c*ADDRW +: ADDRW];
                if (tail_valid && tail_id == CHW'(c))
                    data_q[c] <= tail_data;
            end
        end
    end
endmodule
